// File: rtl/dmem_if.sv
// dmem_if: MEM-stage request, memory-side handshake and status signals of the data-memory wait controller
interface dmem_if;
  logic en;
  logic rd;
  logic wr;
  logic [31:0] addr;
  logic [1:0] size;
  logic sext;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic dmem_wait;
  logic mem_req;
  logic mem_we;
  logic [29:0] mem_addr;
  logic [3:0] mem_be;
  logic [31:0] mem_wdata;
  logic mem_ack;
  logic [31:0] mem_rdata;
  logic err_timeout;
  logic err_misalign;
  modport slave (
    input en, rd, wr, addr, size, sext, wdata, mem_ack, mem_rdata,
    output rdata, dmem_wait, mem_req, mem_we, mem_addr, mem_be, mem_wdata, err_timeout, err_misalign
  );
  modport master (
    output en, rd, wr, addr, size, sext, wdata, mem_ack, mem_rdata,
    input rdata, dmem_wait, mem_req, mem_we, mem_addr, mem_be, mem_wdata, err_timeout, err_misalign
  );
endinterface

// File: rtl/dmem_wait_ctrl.sv
// dmem_wait_ctrl: stalls the MEM stage while one big-endian data-memory access runs, with timeout and alignment checks
module dmem_wait_ctrl #(
  parameter int TIMEOUT = 255
) (
  input logic clk,
  input logic rst,
  dmem_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d, wd_q, wd_d, rdata_q, rdata_d;
  logic [1:0] size_q, size_d;
  logic [3:0] be_q, be_d;
  logic sext_q, sext_d, we_q, we_d, to_q, to_d, mis_q, mis_d;
  logic acc, aligned, new_acc;
  logic [4:0] sh;
  logic [31:0] lane, ext;
  always_comb begin
    acc = bus.en & (bus.rd | bus.wr);
    aligned = bus.size == 2'd0 | (bus.size == 2'd1 ? ~bus.addr[0] : bus.addr[1:0] == 2'b00);
    new_acc = acc & aligned;
    // big-endian: lane 0 lives in the top byte, so shift down by the distance from the top
    sh = size_q == 2'd0 ? {~addr_q[1:0], 3'b000} : {~addr_q[1], 4'b0000};
    lane = bus.mem_rdata >> sh;
    ext = size_q == 2'd0 ? {{24{sext_q & lane[7]}}, lane[7:0]} :
          size_q == 2'd1 ? {{16{sext_q & lane[15]}}, lane[15:0]} : bus.mem_rdata;
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    size_d = size_q;
    sext_d = sext_q;
    we_d = we_q;
    be_d = be_q;
    wd_d = wd_q;
    rdata_d = rdata_q;
    to_d = to_q;
    mis_d = mis_q;
    case (state_q)
      IDLE: begin
        mis_d = mis_q | (acc & ~aligned);
        if (new_acc) begin
          state_d = REQ;
          addr_d = bus.addr;
          size_d = bus.size;
          sext_d = bus.sext;
          we_d = bus.wr;
          be_d = bus.size == 2'd0 ? 4'b1000 >> bus.addr[1:0] :
                 bus.size == 2'd1 ? (bus.addr[1] ? 4'b0011 : 4'b1100) : 4'b1111;
          wd_d = bus.size == 2'd0 ? {4{bus.wdata[7:0]}} :
                 bus.size == 2'd1 ? {2{bus.wdata[15:0]}} : bus.wdata;
        end
      end
      REQ: begin
        state_d = WAIT;
        cnt_d = '0;
      end
      WAIT: begin
        if (bus.mem_ack) begin
          state_d = DONE;
          rdata_d = we_q ? rdata_q : ext;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = DONE;
          rdata_d = '0;
          to_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      addr_q <= '0;
      size_q <= '0;
      sext_q <= 1'b0;
      we_q <= 1'b0;
      be_q <= '0;
      wd_q <= '0;
      rdata_q <= '0;
      to_q <= 1'b0;
      mis_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      size_q <= size_d;
      sext_q <= sext_d;
      we_q <= we_d;
      be_q <= be_d;
      wd_q <= wd_d;
      rdata_q <= rdata_d;
      to_q <= to_d;
      mis_q <= mis_d;
    end
  end
  assign bus.dmem_wait = ~rst & (state_q == IDLE ? new_acc : (state_q == REQ || state_q == WAIT));
  assign bus.mem_req = ~rst & (state_q == REQ);
  assign bus.mem_we = bus.mem_req & we_q;
  assign bus.mem_addr = addr_q[31:2];
  assign bus.mem_be = be_q;
  assign bus.mem_wdata = wd_q;
  assign bus.rdata = rdata_q;
  assign bus.err_timeout = to_q;
  assign bus.err_misalign = mis_q;
endmodule

// File: tb/tb_dmem_wait_ctrl.sv
// tb_dmem_wait_ctrl: randomized scoreboard bench; driver pushes expectations, monitor pops on mem_req and on stall release
module tb_dmem_wait_ctrl;
  localparam int TO = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  dmem_if bus ();
  dmem_wait_ctrl #(.TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {logic we; logic [29:0] addr; logic [3:0] be; logic [31:0] wd;} req_t;
  typedef struct {logic [31:0] rdata; logic to; logic mis; int waits;} cmp_t;
  req_t req_q[$];
  cmp_t cmp_q[$];
  int checks = 0;
  int errors = 0;
  logic [31:0] m_rdata = 0;
  logic m_to = 0;
  logic m_mis = 0;
  int r_delay = 0;
  logic r_drop = 0;
  logic r_spur = 0;
  logic [31:0] r_word = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] w, input logic [1:0] lo, input logic [1:0] sz, input logic sx);
    int n = nbytes(sz);
    logic [31:0] m, v;
    if (n == 4) return w;
    m = (32'h1 << (8 * n)) - 1;
    v = (w >> (8 * (4 - n - int'(lo)))) & m;
    if (sx && v[8 * n - 1]) v = v | ~m;
    return v;
  endfunction

  function automatic logic [3:0] exp_be(input logic [1:0] lo, input logic [1:0] sz);
    int n = nbytes(sz);
    logic [31:0] v = ((32'h1 << n) - 1) << (4 - n - int'(lo));
    return v[3:0];
  endfunction

  function automatic logic [31:0] exp_wd(input logic [31:0] wd, input logic [1:0] sz);
    int n = nbytes(sz);
    return n == 1 ? (wd & 32'hFF) * 32'h01010101 : n == 2 ? (wd & 32'hFFFF) * 32'h00010001 : wd;
  endfunction

  initial begin
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.mem_req) begin
        bus.mem_ack = r_spur;
        bus.mem_rdata = $urandom;
        @(posedge clk);
        #1 bus.mem_ack = 1'b0;
        if (!r_drop) begin
          repeat (r_delay) begin
            @(posedge clk);
            #1;
          end
          bus.mem_ack = 1'b1;
          bus.mem_rdata = r_word;
          @(posedge clk);
          #1 bus.mem_ack = 1'b0;
          bus.mem_rdata = $urandom;
        end
      end
    end
  end

  initial begin
    int wc;
    logic pw;
    req_t e;
    cmp_t c;
    wc = 0;
    pw = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        wc = 0;
        pw = 1'b0;
      end else begin
        if (bus.mem_req) begin
          if (req_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_req: got mem_req=1 expected none at %0t", $time);
          end else begin
            e = req_q.pop_front();
            check("req_we", bus.mem_we, e.we);
            check("req_addr", bus.mem_addr, e.addr);
            check("req_be", bus.mem_be, e.be);
            check("req_wdata", bus.mem_wdata, e.wd);
          end
        end else check("we_outside_req", bus.mem_we, 0);
        if (bus.dmem_wait) wc++;
        else if (pw) begin
          if (cmp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got completion expected none at %0t", $time);
          end else begin
            c = cmp_q.pop_front();
            check("done_rdata", bus.rdata, c.rdata);
            check("done_err_timeout", bus.err_timeout, c.to);
            check("done_err_misalign", bus.err_misalign, c.mis);
            check("done_wait_cycles", wc, c.waits);
          end
          wc = 0;
        end
        pw = bus.dmem_wait;
      end
    end
  end

  task automatic access(input logic r, input logic w, input logic [31:0] a, input logic [1:0] sz, input logic sx,
                        input logic [31:0] wd, input logic [31:0] word, input int d, input logic drop, input logic spur);
    req_t q;
    cmp_t c;
    int n;
    r_delay = d;
    r_drop = drop;
    r_spur = spur;
    r_word = word;
    bus.en = 1'b1;
    bus.rd = r;
    bus.wr = w;
    bus.addr = a;
    bus.size = sz;
    bus.sext = sx;
    bus.wdata = wd;
    if (a % nbytes(sz) != 0) begin
      #1;
      check("mis_wait", bus.dmem_wait, 0);
      check("mis_req", bus.mem_req, 0);
      @(posedge clk);
      #1;
      m_mis = 1'b1;
      check("mis_flag", bus.err_misalign, 1);
      check("mis_rdata", bus.rdata, m_rdata);
      check("mis_stays_idle", bus.dmem_wait, 0);
      bus.en = 1'b0;
      return;
    end
    q.we = w;
    q.addr = a[31:2];
    q.be = exp_be(a[1:0], sz);
    q.wd = exp_wd(wd, sz);
    req_q.push_back(q);
    if (drop) begin
      m_to = 1'b1;
      m_rdata = 0;
      c.waits = 2 + TO;
    end else begin
      if (!w) m_rdata = exp_load(word, a[1:0], sz, sx);
      c.waits = 3 + d;
    end
    c.rdata = m_rdata;
    c.to = m_to;
    c.mis = m_mis;
    cmp_q.push_back(c);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      bus.rd = 1'($urandom);
      bus.wr = 1'($urandom);
      bus.addr = $urandom;
      bus.size = 2'($urandom);
      bus.sext = 1'($urandom);
      bus.wdata = $urandom;
    end while (bus.dmem_wait && n < 50);
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL stall_bound: got dmem_wait still 1 after %0d cycles expected release", n);
    end
    @(posedge clk);
    #1 bus.en = 1'b0;
  endtask

  task automatic rand_access();
    int k;
    logic [1:0] sz;
    logic [31:0] a;
    k = $urandom_range(0, 2);
    sz = 2'($urandom);
    a = $urandom;
    if ($urandom_range(0, 4) != 0) a = a & ~(nbytes(sz) - 1);
    access(k != 1, k != 0, a, sz, 1'($urandom), $urandom, $urandom, $urandom_range(0, 2),
           $urandom_range(0, 9) == 0, 1'($urandom));
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    bus.en = 1'b1;
    bus.rd = 1'b1;
    bus.wr = 1'b0;
    bus.addr = '0;
    bus.size = 2'd2;
    bus.sext = 1'b0;
    bus.wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_wait", bus.dmem_wait, 0);
    check("rst_hold_req", bus.mem_req, 0);
    rst = 1'b0;
    bus.en = 1'b0;
    #1;
    check("rst_rdata", bus.rdata, 0);
    check("rst_err_timeout", bus.err_timeout, 0);
    check("rst_err_misalign", bus.err_misalign, 0);
    check("rst_mem_be", bus.mem_be, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    access(1, 0, 32'h100, 2'd2, 0, 0, 32'hDEADBEEF, 0, 0, 0);
    access(1, 0, 32'h103, 2'd0, 1, 0, 32'h000000F0, 0, 0, 0);
    access(1, 0, 32'h103, 2'd0, 0, 0, 32'h000000F0, 1, 0, 1);
    access(0, 1, 32'h102, 2'd1, 0, 32'h1234ABCD, $urandom, 2, 0, 0);
    access(1, 0, 32'h101, 2'd2, 0, 0, $urandom, 0, 0, 0);
    access(1, 0, 32'h200, 2'd2, 0, 0, $urandom, 0, 1, 0);
    repeat (200) rand_access();
    r_drop = 1'b1;
    r_spur = 1'b0;
    bus.en = 1'b1;
    bus.rd = 1'b1;
    bus.wr = 1'b0;
    bus.addr = $urandom & 32'hFFFFFFFC;
    bus.size = 2'd2;
    req_q.push_back('{1'b0, bus.addr[31:2], 4'hF, bus.wdata});
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    check("midrst_wait", bus.dmem_wait, 0);
    check("midrst_req", bus.mem_req, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    bus.en = 1'b0;
    m_rdata = 0;
    m_to = 1'b0;
    m_mis = 1'b0;
    bus.mem_ack = 1'b1;
    bus.mem_rdata = $urandom | 32'h1;
    #1;
    check("late_ack_wait", bus.dmem_wait, 0);
    @(posedge clk);
    #1 bus.mem_ack = 1'b0;
    check("late_ack_rdata", bus.rdata, 0);
    check("late_ack_err_timeout", bus.err_timeout, 0);
    check("late_ack_err_misalign", bus.err_misalign, 0);
    check("late_ack_req", bus.mem_req, 0);
    repeat (20) rand_access();
    repeat (3) @(posedge clk);
    check("req_queue_drained", req_q.size(), 0);
    check("cmp_queue_drained", cmp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
